// File: rtl/gen_gamma_stream_ctrl.sv
// gen_gamma_stream_ctrl
// Bit-serial Elias-gamma decoder controller. It counts the unary zero
// prefix, collects the same number of suffix bits behind the leading one,
// and presents the assembled value on a valid/ready output port.
// A prefix longer than OUT_W-1 zeros raises a one-cycle err pulse. The
// offending zero is dropped and decoding restarts on the next bit.
// Optional feature macro: GEN_GAMMA_MINUS1_EN. When it is defined, the
// value is presented minus one, which undoes the coder's +1 offset.
module gen_gamma_stream_ctrl #(
   parameter int OUT_W = 9
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err,
   output logic             busy
);

   localparam int            ZW   = $clog2(OUT_W);
   localparam logic [ZW-1:0] ZMAX = ZW'(OUT_W - 1);
   localparam logic [ZW-1:0] ZONE = ZW'(1);

   typedef enum logic [1:0] {
      PREFIX = 2'd0,
      SUFFIX = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [ZW-1:0]    zcnt_reg, zcnt_next;
   logic [ZW-1:0]    rem_reg, rem_next;
   logic [OUT_W-1:0] shreg_reg, shreg_next;
   logic [OUT_W-1:0] data_reg, data_next;
   logic             err_reg, err_next;
   logic             beat;
   logic [OUT_W-1:0] shifted;

   // Map the assembled codeword onto the presented value. The optional
   // offset is removed here so that it adds no latency.
   function automatic logic [OUT_W-1:0] adjust(input logic [OUT_W-1:0] v);
`ifdef GEN_GAMMA_MINUS1_EN
      return v - 1'b1;
`else
      return v;
`endif
   endfunction

   assign bit_ready = (state_reg != HOLD);
   assign beat      = bit_valid && bit_ready;
   assign shifted   = {shreg_reg[OUT_W-2:0], bit_in};
   assign out_data  = data_reg;
   assign out_valid = (state_reg == HOLD);
   assign err       = err_reg;
   assign busy      = (state_reg != PREFIX) || (zcnt_reg != '0);

   // State register and datapath registers; reset clears everything.
   always_ff @(posedge clk or posedge res_n) begin
      if (res_n) begin
         state_reg <= PREFIX;
         zcnt_reg  <= '0;
         rem_reg   <= '0;
         shreg_reg <= '0;
         data_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         zcnt_reg  <= zcnt_next;
         rem_reg   <= rem_next;
         shreg_reg <= shreg_next;
         data_reg  <= data_next;
         err_reg   <= err_next;
      end
   end

   // Next-state logic: prefix count, suffix collection, and hold handshake.
   always_comb begin
      state_next = state_reg;
      zcnt_next  = zcnt_reg;
      rem_next   = rem_reg;
      shreg_next = shreg_reg;
      data_next  = data_reg;
      err_next   = 1'b0;
      case (state_reg)
         PREFIX: begin
            if (beat) begin
               if (!bit_in) begin
                  if (zcnt_reg == ZMAX) begin
                     // Too many zeros for OUT_W. Drop this zero and start over.
                     zcnt_next = '0;
                     err_next  = 1'b1;
                  end else begin
                     zcnt_next = zcnt_reg + 1'b1;
                  end
               end else begin
                  shreg_next = OUT_W'(1);
                  if (zcnt_reg == '0) begin
                     state_next = HOLD;
                     data_next  = adjust(OUT_W'(1));
                  end else begin
                     rem_next   = zcnt_reg;
                     state_next = SUFFIX;
                  end
               end
            end
         end
         SUFFIX: begin
            if (beat) begin
               shreg_next = shifted;
               rem_next   = rem_reg - 1'b1;
               if (rem_reg == ZONE) begin
                  state_next = HOLD;
                  data_next  = adjust(shifted);
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = PREFIX;
               zcnt_next  = '0;
            end
         end
         default: state_next = PREFIX;
      endcase
   end

endmodule

// File: tb/tb_gen_gamma_stream_ctrl.sv
// Self-checking bench for gen_gamma_stream_ctrl (OUT_W = 9).
// The expected values come from Elias-gamma encoding arithmetic: a value v
// with N = floor(log2 v) is sent as N zeros followed by the N+1 bits of v.
// A monitor compares every handed-off codeword against a queue of expected
// values.
module tb_gen_gamma_stream_ctrl;

   localparam int OUT_W = 9;

   logic             clk = 1'b0;
   logic             res_n;
   logic             bit_in;
   logic             bit_valid;
   logic             bit_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             err;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   bit rand_rdy = 1'b0;
   int exp_q[$];

   gen_gamma_stream_ctrl #(.OUT_W(OUT_W)) dut (
      .clk(clk), .res_n(res_n), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] code;
      int          len;
      int          gap_pct;
      int          value;
   } vec_t;

   function automatic int exp_of(input int v);
`ifdef GEN_GAMMA_MINUS1_EN
      return v - 1;
`else
      return v;
`endif
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, req);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Send bits code[len-1:0], MSB first. Each cycle bit_valid is withheld
   // with probability gap_pct.
   task automatic send_bits(input logic [31:0] code, input int len, input int gap_pct);
      int i;
      int guard;
      i = len - 1;
      guard = 0;
      while (i >= 0 && guard < 2000) begin
         bit_in    = code[i];
         bit_valid = ($urandom_range(99) >= gap_pct);
         if (bit_valid && bit_ready) i--;
         step();
         guard++;
      end
      bit_valid = 1'b0;
      if (i >= 0) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got %0d bits left expected 0", i + 1);
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         step();
         guard++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   // Monitor: compare each handed-off codeword and count err pulses.
   initial forever begin
      @(negedge clk);
      if (!res_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got %0d expected none", out_data);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(out_data) !== e) begin
               errors++;
               $display("FAIL out_data got %0d expected %0d", out_data, e);
            end else begin
               $display("ok   out_data = %0d", out_data);
            end
         end
      end
      if (!res_n && err) err_seen++;
   end

   // Optional random back-pressure on out_ready.
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(3) != 0);
   end

   initial begin
      vec_t tbl[7];
      int   e0;
      res_n = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b1;

      tbl[0] = '{32'd1,   1,  0, 1};
      tbl[1] = '{32'd5,   5,  0, 5};
      tbl[2] = '{32'd9,   7,  0, 9};
      tbl[3] = '{32'd6,   5, 50, 6};
      tbl[4] = '{32'd511, 17, 0, 511};
      tbl[5] = '{32'd2,   3,  0, 2};
      tbl[6] = '{32'd6,   5,  0, 6};

      // Check the reset state while reset is asserted.
      repeat (3) step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      res_n = 1'b0;
      step();
      check("rst_bit_ready", bit_ready, 1);

      // Value 1: latency and a single-cycle bit_ready bubble.
      exp_q.push_back(exp_of(1));
      bit_in = 1'b1; bit_valid = 1'b1;
      step();
      bit_valid = 1'b0;
      check("one_out_valid", out_valid, 1);
      check("one_bit_ready_low", bit_ready, 0);
      check("one_out_data", out_data, exp_of(1));
      step();
      check("one_out_valid_drop", out_valid, 0);
      check("one_bit_ready_back", bit_ready, 1);
      wait_drain();

      // Vector table. Entries are sent back-to-back, including 5 then 9.
      for (int k = 0; k < 7; k++) begin
         exp_q.push_back(exp_of(tbl[k].value));
         send_bits(tbl[k].code, tbl[k].len, tbl[k].gap_pct);
      end
      wait_drain();
      check("no_err_table", err_seen, 0);

      // Prefix overflow: the 9th zero pulses err, then "1" decodes as 1.
      send_bits(32'd0, 8, 0);
      check("ovf_busy_before", busy, 1);
      bit_in = 1'b0; bit_valid = 1'b1;
      step();
      bit_valid = 1'b0;
      check("ovf_err_pulse", err, 1);
      check("ovf_busy_cleared", busy, 0);
      step();
      check("ovf_err_drop", err, 0);
      check("ovf_err_count", err_seen, 1);
      exp_q.push_back(exp_of(1));
      send_bits(32'd1, 1, 0);
      wait_drain();

      // "010" with out_ready held low for 5 cycles while bits are offered.
      out_ready = 1'b0;
      exp_q.push_back(exp_of(2));
      send_bits(32'd2, 3, 0);
      for (int c = 0; c < 5; c++) begin
         bit_in = 1'b1; bit_valid = 1'b1;
         check("hold_out_valid", out_valid, 1);
         check("hold_out_data", out_data, exp_of(2));
         check("hold_bit_ready", bit_ready, 0);
         step();
      end
      bit_valid = 1'b0;
      out_ready = 1'b1;
      step();
      check("hold_release_valid", out_valid, 0);
      check("hold_release_ready", bit_ready, 1);
      check("hold_release_busy", busy, 0);
      wait_drain();

      // Reset mid-codeword after "001" of "00111".
      exp_q.push_back(exp_of(5));
      send_bits(32'd5, 5, 0);
      wait_drain();
      send_bits(32'd1, 3, 0);
      check("mid_busy", busy, 1);
      @(posedge clk);
      #2;
      res_n = 1'b1;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_out_data", out_data, 0);
      check("async_busy", busy, 0);
      check("async_err", err, 0);
      @(negedge clk);
      res_n = 1'b0;
      step();
      check("post_rst_ready", bit_ready, 1);
      exp_q.push_back(exp_of(2));
      send_bits(32'd2, 3, 0);
      wait_drain();

      // Random codewords with random gaps and random back-pressure.
      e0 = err_seen;
      rand_rdy = 1'b1;
      for (int n = 0; n < 40; n++) begin
         int kk;
         int v;
         kk = $urandom_range(OUT_W - 1, 0);
         v  = (1 << kk) | ($urandom & ((1 << kk) - 1));
         exp_q.push_back(exp_of(v));
         send_bits(32'(v), 2 * kk + 1, 30);
      end
      wait_drain();
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      check("rand_no_err", err_seen - e0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
